seq_pattern_driver: RTL
=======================

// Module: seq_pattern_driver
// PURPOSE
// - Stimulus/response end of the seq_pattern test netlists: accepts a stream of input vectors with
//   expected outputs, drives them onto a pattern netlist's inputs, and samples its single output
//   after a fixed latency.
// - Compares the sample against the expected value, then counts vectors and mismatches.
// - Records the index of the first failing vector and flags done/pass after the last vector.
// PARAMETERS
// - NUM_IN   3   width of dut_in / vec_data (pattern netlist input count)
// - LATENCY  1   register stages inside the DUT between its inputs and its output (0 = combinational)
// - CNT_W    16  width of vec_cnt, mismatch_cnt and first_fail
// PORTS
// - blif_clk_net    in   1       single clock, rising edge
// - blif_reset_net  in   1       synchronous, active-high reset
// - vec_valid       in   1       vector word valid
// - vec_ready       out  1       driver can accept a vector
// - vec_data        in   NUM_IN  stimulus to apply
// - vec_expect      in   1       expected DUT output for this vector
// - vec_last        in   1       final vector of the sequence
// - dut_in          out  NUM_IN  registered drive to DUT inputs
// - dut_out         in   1       DUT output
// - restart         in   1       one-cycle pulse; leaves DONE and clears all results
// - done            out  1       sequence complete
// - pass            out  1       done && mismatch_cnt==0
// - vec_cnt         out  CNT_W   vectors checked
// - mismatch_cnt    out  CNT_W   mismatching vectors, saturates at all-ones
// - first_fail      out  CNT_W   vec_cnt value of first mismatch; valid when mismatch_cnt!=0
// BEHAVIOUR
// - Reset values: vec_ready=0 during reset, 1 in the first cycle after reset; all other outputs 0
//   (dut_in=0, done=0, pass=0, counters=0). Reset in any state aborts the sequence, returns to IDLE.
// - FSM states: IDLE, WAIT, DONE. All outputs are registered except vec_ready, which is 1 iff the
//   state is IDLE.
// - IDLE, on vec_valid (edge E0):
//   - dut_in<=vec_data; latch vec_expect and vec_last; wcnt<=LATENCY; go to WAIT.
// - WAIT: wcnt decrements each edge. At the edge where wcnt==0 (edge E0+LATENCY+1), sample dut_out:
//   - mism = dut_out != expect_q.
//   - If mism: mismatch_cnt++ (saturating); if mismatch_cnt was 0, first_fail<=vec_cnt.
//   - vec_cnt++ (wraps modulo 2^CNT_W).
//   - Next state is DONE if last_q, else IDLE.
// - Throughput: one vector per LATENCY+2 cycles. vec_valid while vec_ready=0 is ignored; the
//   source holds the vector until accepted.
// - dut_in holds its last value between vectors and in DONE; it is never cleared except by reset.
// - DONE: done=1, pass=(mismatch_cnt==0); vec_ready=0; new vectors are not accepted.
// - restart in DONE: clear done, pass, vec_cnt, mismatch_cnt, first_fail; go to IDLE next cycle;
//   dut_in is kept.
// - restart in IDLE or WAIT: same clearing; any in-flight vector is discarded without being
//   counted; go to IDLE.
// - restart and reset asserted together: reset wins.
// - restart in the same IDLE cycle as vec_valid: restart wins; the vector is not accepted.
// - mismatch_cnt saturation: at all-ones, further mismatches leave it unchanged; vec_cnt still
//   increments.
// TESTING
// - Bench DUT is one flop, out = dut_in[0], LATENCY=1.
//   - Vectors 001/e1, 000/e0, 001/e1 (last) -> vec_ready low 2 cycles per vector; done=1, pass=1,
//     vec_cnt=3, mismatch_cnt=0.
// - Same DUT, vectors 001/e0, 001/e1, 000/e1 (last) -> mismatch_cnt=2, first_fail=0, pass=0, done=1.
// - LATENCY=0 with combinational DUT out = ~dut_in[1]:
//   - Vector 010/e0 -> sampled exactly 1 edge after accept; no mismatch.
//   - vec_ready period is 2 cycles.
// - Reset mid-WAIT (2nd of 3 vectors):
//   - Assert blif_reset_net 1 cycle -> all outputs 0, then vec_ready=1; the next vector is counted
//     as vec_cnt=0.
// - In DONE, pulse restart with vec_valid held high:
//   - Counters clear, done=0, dut_in unchanged.
//   - The vector is accepted one cycle later, in IDLE.
// - CNT_W=2, always-mismatching DUT, 5 vectors -> mismatch_cnt=3 (saturated), vec_cnt=1 (wrapped),
//   first_fail=0.

Source files
------------

// File: rtl/seq_pattern_driver.sv
// seq_pattern_driver: applies stimulus vectors to a pattern netlist and checks its
// single output after a fixed latency. Tracks vector count, saturating mismatch
// count and the index of the first failing vector; flags done/pass after the last.
module seq_pattern_driver #(
    parameter int NUM_IN  = 3,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              vec_valid,
    output logic              vec_ready,
    input  logic [NUM_IN-1:0] vec_data,
    input  logic              vec_expect,
    input  logic              vec_last,
    output logic [NUM_IN-1:0] dut_in,
    input  logic              dut_out,
    input  logic              restart,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  vec_cnt,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [CNT_W-1:0]  first_fail
);

    // Wait counter must hold LATENCY; keep at least one bit for LATENCY 0/1.
    localparam int WCNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic              expect_q;
    logic              last_q;
    logic              accept;
    logic              sample;
    logic              mism;

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) state <= IDLE;
        else                state <= state_nxt;
    end

    // Next-state decode; restart overrides acceptance and sampling.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sample    = 1'b0;
        mism      = (dut_out != expect_q);
        // Ready is forced low while reset is held so the source cannot hand off
        // a vector that the reset would immediately discard.
        vec_ready = (state == IDLE) && !blif_reset_net;
        if (restart) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (vec_valid) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
                WAIT: if (wcnt == '0) begin
                    sample    = 1'b1;
                    state_nxt = last_q ? DONE : IDLE;
                end
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: launch vector, count down latency, score the sampled output.
    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            dut_in       <= '0;
            expect_q     <= 1'b0;
            last_q       <= 1'b0;
            wcnt         <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            vec_cnt      <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
        end else if (restart) begin
            // dut_in deliberately kept: the netlist keeps seeing the last drive.
            done         <= 1'b0;
            pass         <= 1'b0;
            vec_cnt      <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
        end else begin
            if (accept) begin
                dut_in   <= vec_data;
                expect_q <= vec_expect;
                last_q   <= vec_last;
                wcnt     <= WCNT_W'(LATENCY);
            end else if (state == WAIT && wcnt != '0) begin
                wcnt <= wcnt - WCNT_W'(1);
            end
            if (sample) begin
                vec_cnt <= vec_cnt + CNT_W'(1);
                if (mism) begin
                    if (!(&mismatch_cnt)) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                    if (mismatch_cnt == '0) first_fail <= vec_cnt;
                end
                if (last_q) begin
                    done <= 1'b1;
                    pass <= !mism && (mismatch_cnt == '0);
                end
            end
        end
    end

endmodule
